// File: rtl/min_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : min_stream_pkg
//  Purpose  : Shared definitions for the streaming minimum finder:
//             FSM state encodings and default datapath widths.
//  Contents : C_WIDTH  - default operand/result width
//             C_CNT_W  - default element-counter width
//             state_t  - scheduler FSM states
//  Revision : 1.0  initial release
// ============================================================================
package min_stream_pkg;

    localparam int C_WIDTH = 8;
    localparam int C_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : min_stream_pkg
`default_nettype wire

// File: rtl/min_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : min_cmp
//  Purpose  : Purely combinational two-input unsigned minimum.
//             On a tie the 'a' input wins, so the earlier (accumulated)
//             operand is kept when 'a' carries the running minimum.
//  Ports    : a  in  WIDTH  first operand (running minimum)
//             b  in  WIDTH  second operand (new stream element)
//             y  out WIDTH  (a < b) ? a : b ... ties return a
//  Revision : 1.0  initial release
// ============================================================================
module min_cmp
    import min_stream_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // b only wins when strictly smaller, which gives tie -> a.
    assign y = (b < a) ? b : a;

endmodule : min_cmp
`default_nettype wire

// File: rtl/min_stream_sched.sv
`default_nettype none
// ============================================================================
//  Module   : min_stream_sched
//  Purpose  : Sequential frame-minimum finder. One shared min_cmp is
//             time-multiplexed over a framed operand stream (one operand per
//             cycle, valid/ready in), the frame minimum and element count are
//             presented on a valid/ready result port.
//  Ports    : clk        in   1      rising-edge clock
//             rst        in   1      synchronous active-high reset
//             in_valid   in   1      operand valid
//             in_ready   out  1      operand can be accepted
//             in_data    in   WIDTH  operand
//             in_last    in   1      operand closes the frame
//             out_valid  out  1      result valid
//             out_ready  in   1      result consumed
//             out_min    out  WIDTH  frame minimum
//             out_count  out  CNT_W  operands in frame (saturating)
//             out_sat    out  1      count saturated during the frame
//             out_idx    out  CNT_W  0-based position of the minimum
//                                    (only with MIN_STREAM_INDEX_EN)
//  Config   : `define MIN_STREAM_INDEX_EN to add out_idx and index tracking.
//  Revision : 1.0  initial release
// ============================================================================
module min_stream_sched
    import min_stream_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int CNT_W = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
`ifdef MIN_STREAM_INDEX_EN
    ,
    output logic [CNT_W-1:0] out_idx
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [WIDTH-1:0] r_out_min;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_sat;

    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_cnt_max;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sat_nxt;

    // ------------------------------------------------------------------
    // Shared comparator: running minimum against the incoming operand.
    // ------------------------------------------------------------------
    min_cmp #(
        .WIDTH (WIDTH)
    ) u_min_cmp (
        .a (r_acc),
        .b (in_data),
        .y (w_min)
    );

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs (depend on state only, so
    // both ready and valid come straight from registers).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = in_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_xfer_in  = in_valid & in_ready;
    assign w_xfer_out = out_valid & out_ready;
    assign w_cnt_max  = (r_cnt == {CNT_W{1'b1}});

    // Accumulator values after accepting the current operand. The first
    // operand of a frame (IDLE) seeds the accumulator instead of comparing.
    always_comb begin
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_cnt;
        w_sat_nxt = r_sat;
        if (r_state == ST_IDLE) begin
            w_acc_nxt = in_data;
            w_cnt_nxt = CNT_W'(1);
            w_sat_nxt = 1'b0;
        end else begin
            w_acc_nxt = w_min;
            w_cnt_nxt = w_cnt_max ? r_cnt : r_cnt + CNT_W'(1);
            w_sat_nxt = r_sat | w_cnt_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_min   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer_in) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                r_sat <= w_sat_nxt;
                // Result registers only move when the frame closes.
                if (in_last) begin
                    r_out_min   <= w_acc_nxt;
                    r_out_count <= w_cnt_nxt;
                    r_out_sat   <= w_sat_nxt;
                end
            end
        end
    end

    assign out_min   = r_out_min;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

`ifdef MIN_STREAM_INDEX_EN
    // ------------------------------------------------------------------
    // Position of the minimum. The incoming operand's 0-based position
    // equals the current count, which also gives the required saturation.
    // The comparator output differs from acc only when in_data < acc, so
    // ties keep the earlier position without a second comparator.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_out_idx;
    logic [CNT_W-1:0] w_idx_nxt;

    always_comb begin
        w_idx_nxt = r_idx;
        if (r_state == ST_IDLE) begin
            w_idx_nxt = '0;
        end else if (w_min != r_acc) begin
            w_idx_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_out_idx <= '0;
        end else if (w_xfer_in) begin
            r_idx <= w_idx_nxt;
            if (in_last) begin
                r_out_idx <= w_idx_nxt;
            end
        end
    end

    assign out_idx = r_out_idx;
`endif

    // Result consumption only affects the FSM; kept explicit for clarity.
    logic w_unused;
    assign w_unused = w_xfer_out;

endmodule : min_stream_sched
`default_nettype wire

// File: tb/tb_min_stream_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_min_stream_sched
//  Purpose  : Self-checking bench for min_stream_sched. A per-cycle vector
//             table covers normal frames, single-operand frames, result
//             back-pressure and ties; hand-written sequences cover reset in
//             mid-frame and counter saturation on a CNT_W=2 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_min_stream_sched;

    logic       clk = 1'b0;
    logic       rst;

    // Main instance (default widths)
    logic       in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
    logic [7:0] in_data, out_min, out_count;
    logic [7:0] out_idx;

    // Narrow-counter instance (CNT_W = 2)
    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat;
    logic [7:0] b_in_data, b_out_min;
    logic [1:0] b_out_count;
    logic [1:0] b_out_idx;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    min_stream_sched #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_count (out_count),
        .out_sat   (out_sat)
`ifdef MIN_STREAM_INDEX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    min_stream_sched #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_min   (b_out_min),
        .out_count (b_out_count),
        .out_sat   (b_out_sat)
`ifdef MIN_STREAM_INDEX_EN
        ,
        .out_idx   (b_out_idx)
`endif
    );

`ifndef MIN_STREAM_INDEX_EN
    assign out_idx   = '0;
    assign b_out_idx = '0;
`endif

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_min;
        logic [7:0] e_cnt;
        logic       e_sat;
        logic [7:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic ordy,
                       input logic e_rdy, input logic e_ov, input logic [7:0] e_min,
                       input logic [7:0] e_cnt, input logic e_sat, input logic [7:0] e_idx);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_min = e_min;
        t.e_cnt = e_cnt; t.e_sat = e_sat; t.e_idx = e_idx;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input logic e_rdy, input logic e_ov,
                            input logic [7:0] e_min, input logic [7:0] e_cnt,
                            input logic e_sat, input logic [7:0] e_idx);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_min"},   32'(out_min),   32'(e_min));
        chk({tag, ".out_count"}, 32'(out_count), 32'(e_cnt));
        chk({tag, ".out_sat"},   32'(out_sat),   32'(e_sat));
`ifdef MIN_STREAM_INDEX_EN
        chk({tag, ".out_idx"},   32'(out_idx),   32'(e_idx));
`else
        if (e_idx != out_idx) begin end
`endif
    endtask

    task automatic send_b(input logic [7:0] d, input logic l);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = l;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'd1;
        in_last    = 1'b1;
        out_ready  = 1'b0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_in_last  = 1'b0;
        b_out_ready = 1'b1;

        // ---- Vector table: v, d, l, ordy | rdy, ov, min, cnt, sat, idx ----
        // Frame 9,3,7: result the cycle after 7 is accepted
        add(1,  9, 0, 1,  1, 0,  0, 0, 0, 0);
        add(1,  3, 0, 1,  1, 0,  0, 0, 0, 0);
        add(1,  7, 1, 1,  1, 0,  0, 0, 0, 0);
        add(0,  0, 0, 1,  0, 1,  3, 3, 0, 1);
        add(0,  0, 0, 1,  1, 0,  3, 3, 0, 1);
        // Single operand frame; in_valid during DONE ignored
        add(1,  5, 1, 1,  1, 0,  3, 3, 0, 1);
        add(1,  1, 1, 0,  0, 1,  5, 1, 0, 0);
        add(0,  0, 0, 1,  0, 1,  5, 1, 0, 0);
        add(0,  0, 0, 1,  1, 0,  5, 1, 0, 0);
        // Frame 6,2 then 5 cycles of back-pressure with a pending operand 0
        add(1,  6, 0, 1,  1, 0,  5, 1, 0, 0);
        add(1,  2, 1, 1,  1, 0,  5, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 1, 0,  0, 1, 2, 2, 0, 1);
        add(1,  0, 1, 1,  0, 1,  2, 2, 0, 1);
        // Next frame 10,11 starts cleanly after the result is taken
        add(1, 10, 0, 1,  1, 0,  2, 2, 0, 1);
        add(1, 11, 1, 1,  1, 0,  2, 2, 0, 1);
        add(0,  0, 0, 1,  0, 1, 10, 2, 0, 0);
        add(0,  0, 0, 1,  1, 0, 10, 2, 0, 0);
        // Ties 4,(gap),4,2,2: minimum position stays at first 2
        add(1,  4, 0, 1,  1, 0, 10, 2, 0, 0);
        add(0,  0, 0, 1,  1, 0, 10, 2, 0, 0);
        add(1,  4, 0, 1,  1, 0, 10, 2, 0, 0);
        add(1,  2, 0, 1,  1, 0, 10, 2, 0, 0);
        add(1,  2, 1, 1,  1, 0, 10, 2, 0, 0);
        add(0,  0, 0, 1,  0, 1,  2, 4, 0, 2);
        add(0,  0, 0, 1,  1, 0,  2, 4, 0, 2);

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        chk_main("reset", 1, 0, 0, 0, 0, 0);
        chk("reset_b.out_valid", 32'(b_out_valid), 32'd0);
        rst = 1'b0;

        // ---- Table run ----
        foreach (vecs[i]) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            in_last   = vecs[i].l;
            out_ready = vecs[i].ordy;
            chk_main($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_min,
                     vecs[i].e_cnt, vecs[i].e_sat, vecs[i].e_idx);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // ---- Reset mid-frame: partial frame discarded ----
        send_a(8'd1, 1'b0);
        send_a(8'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_main("midrst", 1, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        send_a(8'd8, 1'b0);
        send_a(8'd6, 1'b1);
        chk_main("after_rst", 0, 1, 6, 2, 0, 1);
        @(negedge clk);
        chk("after_rst.idle_ready", 32'(in_ready), 32'd1);

        // ---- Narrow counter: exactly 3 operands (no saturation) ----
        send_b(8'd7, 1'b0);
        send_b(8'd7, 1'b0);
        send_b(8'd7, 1'b1);
        chk("sat3.out_valid", 32'(b_out_valid), 32'd1);
        chk("sat3.out_min",   32'(b_out_min),   32'd7);
        chk("sat3.out_count", 32'(b_out_count), 32'd3);
        chk("sat3.out_sat",   32'(b_out_sat),   32'd0);
`ifdef MIN_STREAM_INDEX_EN
        chk("sat3.out_idx",   32'(b_out_idx),   32'd0);
`endif
        @(negedge clk);

        // ---- Narrow counter: 6 operands, minimum 1 ----
        send_b(8'd5, 1'b0);
        send_b(8'd3, 1'b0);
        send_b(8'd1, 1'b0);
        send_b(8'd4, 1'b0);
        send_b(8'd1, 1'b0);
        send_b(8'd2, 1'b1);
        chk("sat6.out_valid", 32'(b_out_valid), 32'd1);
        chk("sat6.out_min",   32'(b_out_min),   32'd1);
        chk("sat6.out_count", 32'(b_out_count), 32'd3);
        chk("sat6.out_sat",   32'(b_out_sat),   32'd1);
`ifdef MIN_STREAM_INDEX_EN
        chk("sat6.out_idx",   32'(b_out_idx),   32'd2);
`endif
        @(negedge clk);
        chk("sat6.idle_valid", 32'(b_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_min_stream_sched
`default_nettype wire
